// File: rtl/stage4_types_pkg.sv
// stage4_types_pkg: shared types for the stage4 decode/execute pipeline.
//   uop_t            - one micro-op word
//   UOP_MAX_PER_INST - maximum uops decode can emit for one instruction
//   uop_bundle_t     - one decoded instruction, slot 0 first
//   uq_entry_t       - uop queue storage entry {uop, last-of-bundle}
package stage4_types_pkg;

  localparam int unsigned UOP_MAX_PER_INST = 4;

  typedef logic [15:0] uop_t;

  typedef uop_t [UOP_MAX_PER_INST-1:0] uop_bundle_t;

  typedef struct packed {
    uop_t uop;
    logic last;
  } uq_entry_t;

endpackage

// File: rtl/stage4_pipe_if.sv
// stage4_pipe_if: signals between stage4 decode and the uop queue.
//   queue modport - bundle, in_valid and in_num_uops flow into the queue;
//                   uop, out_valid and out_last flow out toward execute.
interface stage4_pipe_if;
  import stage4_types_pkg::*;

  uop_bundle_t                             bundle;
  logic                                    in_valid;
  logic [$clog2(UOP_MAX_PER_INST+1)-1:0]   in_num_uops;
  uop_t                                    uop;
  logic                                    out_valid;
  logic                                    out_last;

  modport queue (
    input  bundle,
    input  in_valid,
    input  in_num_uops,
    output uop,
    output out_valid,
    output out_last
  );

endinterface

// File: rtl/stage4_uop_queue.sv
// stage4_uop_queue: circular micro-op queue between decode and execute.
// Accepts one whole bundle (0..UOP_MAX_PER_INST uops) per handshake and
// issues one uop per cycle in program order.
//   CLK, RST     - clock, synchronous active-high reset
//   flush        - discard all queued uops and any incoming bundle
//   in_valid     - decode presents a bundle
//   in_ready     - room for a maximum-size bundle (registered state only)
//   in_num_uops  - uops in the bundle (clamped to UOP_MAX_PER_INST)
//   in_uops      - bundle slots, slot 0 first
//   out_valid    - out_uop holds a valid uop
//   out_ready    - execute consumes out_uop
//   out_uop      - head uop
//   out_last     - head uop ends its bundle
//   count        - current occupancy
module stage4_uop_queue #(
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned UOP_MAX_PER_INST = stage4_types_pkg::UOP_MAX_PER_INST
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$clog2(UOP_MAX_PER_INST+1)-1:0]  in_num_uops,
  input  stage4_types_pkg::uop_bundle_t          in_uops,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output stage4_types_pkg::uop_t                 out_uop,
  output logic                                   out_last,
  output logic [$clog2(DEPTH+1)-1:0]             count
);
  import stage4_types_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(UOP_MAX_PER_INST+1);
  localparam int unsigned CW = $clog2(DEPTH+1);

  uq_entry_t         mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [NW-1:0]     n_eff;
  logic [CW-1:0]     free_slots;
  logic              push;
  logic              pop;

  always_comb begin
    free_slots = CW'(DEPTH) - count;
    in_ready   = !RST && !flush && (free_slots >= CW'(UOP_MAX_PER_INST));
    out_valid  = !RST && !flush && (count != '0);
    n_eff      = (in_num_uops > NW'(UOP_MAX_PER_INST)) ? NW'(UOP_MAX_PER_INST)
                                                       : in_num_uops;
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    out_uop    = mem[head].uop;
    out_last   = mem[head].last;
  end

  // Payload storage is deliberately left unreset; only pointers and count
  // define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      for (int unsigned i = 0; i < UOP_MAX_PER_INST; i++) begin
        if (i < 32'(n_eff)) begin
          mem[tail + PW'(i)] <= '{uop: in_uops[i], last: (i + 1 == 32'(n_eff))};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(n_eff);
      if (pop)  head <= head + PW'(1);
      // Slot freed by a pop is only reusable from the next cycle, since
      // in_ready looks at the registered count.
      count <= count + (push ? CW'(n_eff) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

endmodule
